// File: rtl/cache_port_arbiter.sv
// Shares one cache port between an instruction-fetch port and a data port.
// D requests win by default; a starvation counter forces an I grant, and a grant timeout aborts stuck accesses.
module cache_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_din,
  input  logic [2:0]  d_storecntrl,
  input  logic [4:0]  d_loadcntrl,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        c_ren,
  output logic        c_wen,
  output logic [31:0] c_addr,
  output logic [31:0] c_din,
  output logic [2:0]  c_storecntrl,
  output logic [4:0]  c_loadcntrl,
  input  logic        c_rdy,
  input  logic [31:0] c_dout
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SL      = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic          err_flag, err_nxt;
  logic          grant_i, grant_d, rd_load;
  logic          d_any, granting;

  logic [31:0]   lat_addr, lat_din;
  logic [2:0]    lat_st;
  logic [4:0]    lat_ld;
  logic          lat_wr, lat_is_i;

  assign d_any = d_ren | d_wen;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      to_cnt     <= '0;
      err_flag   <= 1'b0;
      lat_addr   <= '0;
      lat_din    <= '0;
      lat_st     <= '0;
      lat_ld     <= '0;
      lat_wr     <= 1'b0;
      lat_is_i   <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      to_cnt     <= to_nxt;
      err_flag   <= err_nxt;
      if (grant_d) begin
        lat_addr <= d_addr;
        lat_din  <= d_din;
        lat_st   <= d_storecntrl;
        lat_ld   <= d_loadcntrl;
        lat_wr   <= d_wen;
        lat_is_i <= 1'b0;
      end else if (grant_i) begin
        lat_addr <= i_addr;
        lat_din  <= '0;
        lat_st   <= '0;
        lat_ld   <= '0;
        lat_wr   <= 1'b0;
        lat_is_i <= 1'b1;
      end
      if (rd_load) begin
        if (lat_is_i) i_rdata <= c_dout;
        else          d_rdata <= c_dout;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    to_nxt     = to_cnt;
    err_nxt    = err_flag;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    rd_load    = 1'b0;
    case (state)
      IDLE: begin
        to_nxt  = '0;
        err_nxt = 1'b0;
        // D wins unless I is waiting and D has already had its quota in a row
        if (d_any && (!i_req || starve_cnt < SL)) begin
          grant_d    = 1'b1;
          state_nxt  = GRANT_D;
          starve_nxt = i_req ? starve_cnt + 1'b1 : '0;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_nxt  = GRANT_I;
          starve_nxt = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (c_rdy) begin
          state_nxt = RESP;
          rd_load   = !lat_wr;
        end else begin
          to_nxt = to_cnt + 1'b1;
          if (to_cnt == TO_LAST) begin
            state_nxt = RESP;
            err_nxt   = 1'b1;
          end
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign granting     = (state == GRANT_I) || (state == GRANT_D);
  assign c_ren        = granting && !lat_wr;
  assign c_wen        = granting && lat_wr;
  assign c_addr       = granting ? lat_addr : 32'h0;
  assign c_din        = granting ? lat_din  : 32'h0;
  assign c_storecntrl = granting ? lat_st   : 3'h0;
  assign c_loadcntrl  = granting ? lat_ld   : 5'h0;

  assign i_ack = (state == RESP) && lat_is_i;
  assign d_ack = (state == RESP) && !lat_is_i;
  assign i_err = i_ack && err_flag;
  assign d_err = d_ack && err_flag;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: directed scenarios plus a randomized
// phase, all compared each cycle against a transaction-level model of the arbiter.
module tb_cache_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_ack, i_err;
  logic [31:0] i_rdata;
  logic        d_ren = 1'b0, d_wen = 1'b0;
  logic [31:0] d_addr = 32'h0, d_din = 32'h0;
  logic [2:0]  d_storecntrl = 3'h0;
  logic [4:0]  d_loadcntrl = 5'h0;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic        c_ren, c_wen;
  logic [31:0] c_addr, c_din;
  logic [2:0]  c_storecntrl;
  logic [4:0]  c_loadcntrl;
  logic        c_rdy = 1'b0;
  logic [31:0] c_dout = 32'h0;

  cache_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_din(d_din),
    .d_storecntrl(d_storecntrl), .d_loadcntrl(d_loadcntrl),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .c_ren(c_ren), .c_wen(c_wen), .c_addr(c_addr), .c_din(c_din),
    .c_storecntrl(c_storecntrl), .c_loadcntrl(c_loadcntrl),
    .c_rdy(c_rdy), .c_dout(c_dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checkOutput(name, {31'h0, act}, {31'h0, exp});
  endtask

  task automatic checkStr(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  task automatic noteFail(input string name, input int limit);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: no response within %0d cycles (expected one)", name, limit);
  endtask

  // Cache responder: mode 0 never ready, 1 ready after a fixed number of grant cycles, 2 random.
  int          cache_mode = 1;
  int          rsp_delay  = 1;
  int          gcnt       = 0;
  logic [31:0] cache_dout = 32'h0;
  bit          force_rdy  = 1'b0;

  always @(posedge clk) begin
    #2;
    if (cache_mode == 1) begin
      if (c_ren || c_wen) begin
        gcnt++;
        c_rdy = (gcnt == rsp_delay) || force_rdy;
      end else begin
        gcnt  = 0;
        c_rdy = force_rdy;
      end
      c_dout = cache_dout;
    end else if (cache_mode == 2) begin
      c_rdy  = ($urandom_range(0, 3) == 0);
      c_dout = $urandom;
    end else begin
      c_rdy  = force_rdy;
      c_dout = cache_dout;
    end
  end

  // Transaction-level model: one outstanding access (m_active), then a one-cycle
  // response (m_ack); D wins arbitration until it has won STARVE_LIMIT times in a row over a waiting I.
  bit          m_active = 0, m_is_i = 0, m_wr = 0, m_ack = 0, m_err = 0, m_dq;
  logic [31:0] m_addr, m_din, m_irdata, m_drdata;
  logic [2:0]  m_st;
  logic [4:0]  m_ld;
  int          m_age = 0, m_streak = 0;
  string       m_log = "";

  always @(posedge clk) begin
    if (!rst) begin
      m_active = 0; m_ack = 0; m_err = 0; m_wr = 0; m_is_i = 0;
      m_addr = 0; m_din = 0; m_st = 0; m_ld = 0;
      m_irdata = 0; m_drdata = 0; m_age = 0; m_streak = 0;
    end else if (m_ack) begin
      m_ack = 0;
      m_err = 0;
    end else if (m_active) begin
      m_age++;
      if (c_rdy) begin
        if (!m_wr) begin
          if (m_is_i) m_irdata = c_dout;
          else        m_drdata = c_dout;
        end
        m_active = 0; m_ack = 1; m_err = 0;
      end else if (m_age == TIMEOUT) begin
        m_active = 0; m_ack = 1; m_err = 1;
      end
    end else begin
      m_dq = d_ren || d_wen;
      if (m_dq && (!i_req || m_streak < STARVE_LIMIT)) begin
        m_is_i = 0; m_wr = d_wen; m_addr = d_addr; m_din = d_din;
        m_st = d_storecntrl; m_ld = d_loadcntrl;
        m_streak = i_req ? m_streak + 1 : 0;
        m_active = 1; m_age = 0; m_log = {m_log, "D"};
      end else if (i_req) begin
        m_is_i = 1; m_wr = 0; m_addr = i_addr; m_din = 0; m_st = 0; m_ld = 0;
        m_streak = 0;
        m_active = 1; m_age = 0; m_log = {m_log, "I"};
      end
    end
  end

  int cren_total = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      checkBit("c_ren", c_ren, m_active && !m_wr);
      checkBit("c_wen", c_wen, m_active && m_wr);
      checkOutput("c_addr", c_addr, m_active ? m_addr : 32'h0);
      checkOutput("c_din", c_din, m_active ? m_din : 32'h0);
      checkOutput("c_storecntrl", {29'h0, c_storecntrl}, m_active ? {29'h0, m_st} : 32'h0);
      checkOutput("c_loadcntrl", {27'h0, c_loadcntrl}, m_active ? {27'h0, m_ld} : 32'h0);
      checkBit("i_ack", i_ack, m_ack && m_is_i);
      checkBit("i_err", i_err, m_ack && m_is_i && m_err);
      checkBit("d_ack", d_ack, m_ack && !m_is_i);
      checkBit("d_err", d_err, m_ack && !m_is_i && m_err);
      checkOutput("i_rdata", i_rdata, m_irdata);
      checkOutput("d_rdata", d_rdata, m_drdata);
      if (c_ren === 1'b1) cren_total++;
    end
  end

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dren, input logic dwen,
                               input logic [31:0] daddr, input logic [31:0] ddin,
                               input logic [2:0] st, input logic [4:0] ld);
    @(posedge clk); #1;
    i_req = ireq; i_addr = iaddr;
    d_ren = dren; d_wen = dwen; d_addr = daddr; d_din = ddin;
    d_storecntrl = st; d_loadcntrl = ld;
  endtask

  task automatic dropAll();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0, 5'h0);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b0;
    i_req = 0; d_ren = 0; d_wen = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic waitAck(input string name, input int limit,
                         output bit gi, output bit gd, output bit gie, output bit gde);
    bit done;
    gi = 0; gd = 0; gie = 0; gde = 0; done = 0;
    for (int k = 0; k < limit && !done; k++) begin
      @(negedge clk);
      if (i_ack === 1'b1 || d_ack === 1'b1) begin
        gi = i_ack; gd = d_ack; gie = i_err; gde = d_err; done = 1;
      end
    end
    if (!done) noteFail(name, limit);
  endtask

  task automatic randomPhase(input int ncyc);
    bit          saw_i, saw_d, draining;
    logic [1:0]  op;
    logic [31:0] r;
    int          c;
    saw_i = 0; saw_d = 0; draining = 0; c = 0;
    while (c < ncyc + 300) begin
      if (c >= ncyc) draining = 1;
      if (draining && !i_req && !d_ren && !d_wen) break;
      @(posedge clk); #1;
      if (i_req && saw_i) i_req = 0;
      else if (!i_req && !draining && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if ((d_ren || d_wen) && saw_d) begin
        d_ren = 0; d_wen = 0;
      end else if (!(d_ren || d_wen) && !draining && $urandom_range(0, 2) == 0) begin
        op = 2'($urandom_range(1, 3));
        d_wen = op[1]; d_ren = op[0];
        d_addr = $urandom; d_din = $urandom;
        r = $urandom;
        d_storecntrl = r[2:0]; d_loadcntrl = r[8:4];
      end
      @(negedge clk);
      saw_i = (i_ack === 1'b1);
      saw_d = (d_ack === 1'b1);
      c++;
    end
    if (i_req || d_ren || d_wen) noteFail("random drain", ncyc + 300);
  endtask

  initial begin
    bit    gi, gd, gie, gde, seen;
    int    cstart, mstart;
    string alog;

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    checkBit("reset c_ren", c_ren, 1'b0);
    checkBit("reset i_ack", i_ack, 1'b0);
    checkOutput("reset d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // Instruction fetch with a three-cycle cache response
    $display("[TB] I fetch, 3-cycle cache latency");
    cache_mode = 1; rsp_delay = 3; cache_dout = 32'hDEADBEEF;
    cstart = cren_total;
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0, 5'h0);
    waitAck("i fetch ack", 20, gi, gd, gie, gde);
    checkBit("i fetch acked on I", gi, 1'b1);
    checkBit("i fetch err", gie, 1'b0);
    dropAll();
    @(negedge clk);
    checkBit("i_ack single cycle", i_ack, 1'b0);
    checkOutput("i fetch c_ren cycles", 32'(cren_total - cstart), 32'd3);
    checkOutput("i fetch rdata", i_rdata, 32'hDEADBEEF);
    checkOutput("model i rdata", m_irdata, 32'hDEADBEEF);

    // Data write with both d_ren and d_wen set: write wins
    $display("[TB] D write with d_ren also set");
    rsp_delay = 2; cache_dout = 32'hCAFEF00D;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 3'b010, 5'b00011);
    @(negedge clk);
    @(negedge clk);
    checkBit("write c_wen", c_wen, 1'b1);
    checkBit("write c_ren", c_ren, 1'b0);
    checkOutput("write c_din", c_din, 32'h12345678);
    checkOutput("write c_addr", c_addr, 32'h40);
    waitAck("d write ack", 20, gi, gd, gie, gde);
    checkBit("d write acked on D", gd, 1'b1);
    dropAll();
    @(negedge clk);
    checkOutput("write leaves d_rdata", d_rdata, 32'h0);

    // Data read that the cache never answers
    $display("[TB] D read timeout");
    cache_mode = 0; cache_dout = 32'h0BADF00D;
    cstart = cren_total;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 3'h0, 5'h1);
    waitAck("timeout ack", TIMEOUT + 20, gi, gd, gie, gde);
    checkBit("timeout d_ack", gd, 1'b1);
    checkBit("timeout d_err", gde, 1'b1);
    checkOutput("timeout grant cycles", 32'(cren_total - cstart), 32'd64);
    dropAll();
    @(negedge clk);
    checkBit("timeout d_err single cycle", d_err, 1'b0);
    checkOutput("timeout leaves d_rdata", d_rdata, 32'h0);

    // Stray c_rdy with nothing outstanding
    $display("[TB] c_rdy while idle");
    cache_mode = 1;
    @(posedge clk); #1 force_rdy = 1'b1;
    @(posedge clk); #1 force_rdy = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (i_ack !== 1'b0 || d_ack !== 1'b0 || c_ren !== 1'b0 || c_wen !== 1'b0) seen = 1;
    end
    checkBit("idle c_rdy no activity", seen, 1'b0);

    // Both ports held: D gets STARVE_LIMIT grants, then I
    $display("[TB] starvation limit");
    doReset();
    cache_mode = 1; rsp_delay = 1; cache_dout = 32'h00C0FFEE;
    mstart = m_log.len();
    alog = "";
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 32'h84, 32'h0, 3'h0, 5'h2);
    for (int t = 0; t < 10; t++) begin
      waitAck("starve ack", 20, gi, gd, gie, gde);
      if (gd) alog = {alog, "D"};
      else if (gi) alog = {alog, "I"};
    end
    dropAll();
    checkStr("starve DUT grant order", alog, "DDDDIDDDDI");
    checkStr("starve model grant order", m_log.substr(mstart, mstart + 9), "DDDDIDDDDI");

    // Reset on the second GRANT_I cycle aborts silently
    $display("[TB] reset during grant");
    cache_mode = 0;
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0, 5'h0);
    @(negedge clk);
    @(negedge clk);
    checkBit("abort first grant c_ren", c_ren, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    checkBit("abort c_ren low", c_ren, 1'b0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (i_ack !== 1'b0) seen = 1;
    end
    checkBit("abort no i_ack", seen, 1'b0);
    cache_mode = 1; rsp_delay = 2; cache_dout = 32'h55AA55AA;
    applyStimulus(1'b1, 32'h204, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0, 5'h0);
    waitAck("post-reset ack", 20, gi, gd, gie, gde);
    checkBit("post-reset i_ack", gi, 1'b1);
    dropAll();
    @(negedge clk);
    checkOutput("post-reset i_rdata", i_rdata, 32'h55AA55AA);

    // Random traffic from both requesters against a random cache
    $display("[TB] random traffic");
    cache_mode = 2;
    randomPhase(1500);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
